// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
// Build option LOADER_CHECKSUM_EN adds the trailing checksum byte check.
package loader_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] LOAD_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted data bytes big-endian into 32-bit words and flags the 4th byte.
module word_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_last_c,
  output logic [WORD_W-1:0] o_word_c
);

  logic [1:0]  r_idx;
  logic [23:0] r_partial;

  // First three bytes of the word shift in from the low end
  always_ff @(posedge clock) begin
    if (clear) begin
      r_idx     <= '0;
      r_partial <= '0;
    end else if (i_accept) begin
      r_idx     <= r_idx + 2'd1;
      r_partial <= {r_partial[15:0], i_byte};
    end
  end

  assign o_last_c = i_accept && (r_idx == 2'd3);
  assign o_word_c = {r_partial, i_byte};

endmodule

// File: rtl/program_loader.sv
// Serial program loader: length header, big-endian data words, instruction-memory writes.
// Build option LOADER_CHECKSUM_EN enables the trailing mod-256 checksum byte.
module program_loader
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_write,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        cpu_clear,
  output logic        done,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_len_full;
  logic               w_accept;
  logic               w_data_accept;
  logic               w_last;
  logic [WORD_W-1:0]  w_word;
  logic               r_byte_ready;
  logic               r_imem_write;
  logic [WORD_W-1:0]  r_imem_address;
  logic [WORD_W-1:0]  r_imem_data;
  logic               r_cpu_clear;
  logic               r_done;

  assign w_accept      = byte_valid && r_byte_ready;
  assign w_data_accept = w_accept && (r_state == S_DATA);
  assign w_len_full    = {r_len[CNT_W-1:BYTE_W], byte_in};
  assign w_cnt_inc     = r_word_cnt + CNT_W'(1);

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
  logic [BYTE_W-1:0] w_csum_total;
  logic              r_error;

  assign w_csum_total = r_csum + byte_in;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_csum  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_data_accept) r_csum <= w_csum_total;
      r_error <= (w_state_next == S_ERROR);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  word_assembler u_asm (
    .clock    (clock),
    .clear    (clear),
    .i_accept (w_data_accept),
    .i_byte   (byte_in),
    .o_last_c (w_last),
    .o_word_c (w_word)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_state_next = S_LEN_LO;
      S_LEN_LO: if (w_accept) w_state_next = (w_len_full == '0) ? S_POST : S_DATA;
      S_DATA:   if (w_last && (w_cnt_inc == r_len)) w_state_next = S_POST;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:   if (w_accept) w_state_next = (w_csum_total == '0) ? S_DONE : S_ERROR;
`endif
      default:  w_state_next = r_state;
    endcase
  end

  // done lags entry into DONE by one cycle so it never coincides with the last write
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_word_cnt     <= '0;
      r_byte_ready   <= 1'b0;
      r_imem_write   <= 1'b0;
      r_imem_address <= '0;
      r_imem_data    <= '0;
      r_cpu_clear    <= 1'b1;
      r_done         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && (r_state == S_LEN_HI)) r_len[CNT_W-1:BYTE_W] <= byte_in;
      if (w_accept && (r_state == S_LEN_LO)) r_len <= w_len_full;
      if (w_last) begin
        r_word_cnt     <= w_cnt_inc;
        r_imem_address <= LOAD_BASE_ADDR + WORD_W'({r_word_cnt, 2'b00});
        r_imem_data    <= w_word;
      end
      r_imem_write <= w_last;
      r_byte_ready <= (w_state_next == S_LEN_HI) || (w_state_next == S_LEN_LO) ||
                      (w_state_next == S_DATA)   || (w_state_next == S_CSUM);
      r_cpu_clear  <= (w_state_next != S_DONE);
      r_done       <= (r_state == S_DONE);
    end
  end

  assign byte_ready   = r_byte_ready;
  assign imem_write   = r_imem_write;
  assign imem_address = r_imem_address;
  assign imem_data    = r_imem_data;
  assign cpu_clear    = r_cpu_clear;
  assign done         = r_done;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table plus write scoreboard.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_write;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        cpu_clear;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] n;
    logic [31:0] w [3];
    bit          gaps;
    bit          csum_bad;
    bit          start_mid;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t  exp_q [$];
  vec_t vecs  [4];
  logic prev_wr = 1'b0;

  program_loader dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_write   (imem_write),
    .imem_address (imem_address),
    .imem_data    (imem_data),
    .cpu_clear    (cpu_clear),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard: every write pops one expected {addr,data}; writes last one cycle
  always @(negedge clock) begin
    if (imem_write === 1'b1) begin
      check("wr_width", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h", imem_address, imem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", imem_address, e.addr);
        check("wr_data", imem_data, e.data);
      end
    end
    prev_wr = imem_write;
  end

  function automatic vec_t mk(input logic [15:0] n, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input bit gaps, input bit csum_bad,
                              input bit start_mid, input bit exp_done, input bit exp_err);
    vec_t v;
    v.n = n; v.w[0] = a; v.w[1] = b; v.w[2] = c;
    v.gaps = gaps; v.csum_bad = csum_bad; v.start_mid = start_mid;
    v.exp_done = exp_done; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic do_reset();
    clear = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_write", 32'(imem_write), 32'd0);
    check("rst_addr", imem_address, 32'd0);
    check("rst_data", imem_data, 32'd0);
    check("rst_cpu_clear", 32'(cpu_clear), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    exp_q.delete();
    clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit with_start);
    int t;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      @(posedge clock);
      #1;
    end
    byte_in = b; byte_valid = 1'b1; start = with_start;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!byte_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL byte_timeout: byte %h not accepted", b);
    end else begin
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0; start = 1'b0;
  endtask

  task automatic send_session(input vec_t v);
    logic [7:0] sum;
    int         k;
    sum = 8'h00;
    k = 0;
    pulse_start();
    send_byte(v.n[15:8], v.gaps, 1'b0);
    send_byte(v.n[7:0], v.gaps, 1'b0);
    for (int i = 0; i < int'(v.n); i++) begin
      wr_t e;
      logic [31:0] w;
      w = v.w[i];
      e.addr = 32'(4 * i);
      e.data = w;
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        logic [7:0] by;
        by = w[31 - 8*b -: 8];
        sum = sum + by;
        send_byte(by, v.gaps, v.start_mid && (k == 1));
        k++;
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'(8'h00 - sum) + (v.csum_bad ? 8'h01 : 8'h00), v.gaps, 1'b0);
`endif
  endtask

  task automatic wait_end(input string name);
    int t;
    t = 0;
    while (!(done || error) && t < 30) begin
      @(posedge clock);
      #1;
      t++;
    end
    if (!(done || error)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: done %b error %b", name, done, error);
    end
  endtask

  initial begin
    vecs[0] = mk(16'd1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[1] = mk(16'd3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[2] = mk(16'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    vecs[3] = mk(16'd1, 32'h01020304, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    vecs[3] = mk(16'd1, 32'h01020304, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 4; i++) begin
      do_reset();
      send_session(vecs[i]);
      wait_end($sformatf("vec%0d", i));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_cpu_clear", i), 32'(cpu_clear), 32'(!vecs[i].exp_done));
      check($sformatf("vec%0d_ready", i), 32'(byte_ready), 32'd0);
      // start after completion must not rerun the load
      pulse_start();
      repeat (4) @(posedge clock);
      #1;
      check($sformatf("vec%0d_done_sticky", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_err_sticky", i), 32'(error), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ready_after", i), 32'(byte_ready), 32'd0);
      check($sformatf("vec%0d_pending", i), 32'(exp_q.size()), 32'd0);
    end

    // Clear two bytes into the second word, then a fresh one-word load
    begin
      wr_t e;
      do_reset();
      pulse_start();
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h02, 1'b0, 1'b0);
      e.addr = 32'h0; e.data = 32'hCAFEF00D;
      exp_q.push_back(e);
      send_byte(8'hCA, 1'b0, 1'b0);
      send_byte(8'hFE, 1'b0, 1'b0);
      send_byte(8'hF0, 1'b0, 1'b0);
      send_byte(8'h0D, 1'b0, 1'b0);
      send_byte(8'hAA, 1'b0, 1'b0);
      send_byte(8'hBB, 1'b0, 1'b0);
      check("abort_pending", 32'(exp_q.size()), 32'd0);
      do_reset();
      repeat (3) @(posedge clock);
      #1;
      check("abort_no_write_q", 32'(exp_q.size()), 32'd0);
      send_session(mk(16'd1, 32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      wait_end("reload");
      check("reload_done", 32'(done), 32'd1);
      check("reload_pending", 32'(exp_q.size()), 32'd0);
    end

`ifdef LOADER_CHECKSUM_EN
    // Explicit good and bad checksum bytes for data 01 02 03 04 (sum 0x0A)
    begin
      logic [7:0] csum_vals [2];
      csum_vals[0] = 8'hF6;
      csum_vals[1] = 8'hFD;
      for (int j = 0; j < 2; j++) begin
        wr_t e;
        do_reset();
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        e.addr = 32'h0; e.data = 32'h01020304;
        exp_q.push_back(e);
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b0, 1'b0);
        send_byte(csum_vals[j], 1'b0, 1'b0);
        wait_end("csum");
        repeat (2) @(posedge clock);
        #1;
        check("csum_done", 32'(done), 32'(j == 0));
        check("csum_error", 32'(error), 32'(j == 1));
        check("csum_cpu_clear", 32'(cpu_clear), 32'(j == 1));
      end
    end
`endif

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
